// File: rtl/fir_output_stage.sv
`default_nettype none
// ============================================================================
// Module      : fir_output_stage
// Description : Rounds and saturates FIR accumulator results to output samples,
//               buffers them in a small FIFO and streams them out over
//               valid/ready. Keeps saturating debug counters for clipped and
//               dropped results, plus a sticky overflow flag.
// Revision    : 1.0 - initial release
// ============================================================================
module fir_output_stage #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 16,
    parameter int SHIFT = 15,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                    clk3,
    input  logic                    reset,
    input  logic signed [IN_W-1:0]  sum_in,
    input  logic                    sum_valid,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    fifo_full,
    output logic [CNT_W-1:0]        sat_count,
    output logic [CNT_W-1:0]        drop_count,
    output logic                    overflow
);

    localparam int EXT_W = IN_W + 1;
    localparam int PTR_W = $clog2(DEPTH);

    // Output range limits expressed in the widened arithmetic domain.
    localparam logic signed [EXT_W-1:0] C_MAX   = EXT_W'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [EXT_W-1:0] C_MIN   = ~C_MAX;
    localparam logic [PTR_W:0]          C_DEPTH = (PTR_W + 1)'(DEPTH);

    // ------------------------------------------------------------------
    // Stage 1: round / shift / saturate (combinational part)
    // ------------------------------------------------------------------
    // One guard bit so adding the rounding constant to the most positive
    // input cannot wrap.
    logic signed [EXT_W-1:0] w_sum_ext;
    logic signed [EXT_W-1:0] w_rounded;
    logic                    w_clip_hi;
    logic                    w_clip_lo;
    logic [OUT_W-1:0]        w_sample;

    assign w_sum_ext = {sum_in[IN_W-1], sum_in};

    generate
        if (SHIFT > 0) begin : g_round
            localparam logic signed [EXT_W-1:0] C_HALF = EXT_W'(64'sd1 <<< (SHIFT - 1));
            // Adding one half then flooring rounds half toward +inf.
            assign w_rounded = (w_sum_ext + C_HALF) >>> SHIFT;
        end else begin : g_no_round
            assign w_rounded = w_sum_ext;
        end
    endgenerate

    assign w_clip_hi = (w_rounded > C_MAX);
    assign w_clip_lo = (w_rounded < C_MIN);
    assign w_sample  = w_clip_hi ? C_MAX[OUT_W-1:0] :
                       w_clip_lo ? C_MIN[OUT_W-1:0] :
                                   w_rounded[OUT_W-1:0];

    logic [OUT_W-1:0] r_p_data;
    logic             r_p_valid;
    logic [CNT_W-1:0] r_sat_count;

    // Pipeline register holding the rounded sample and its valid flag.
    always_ff @(posedge clk3 or posedge reset) begin
        if (reset) begin
            r_p_data  <= '0;
            r_p_valid <= 1'b0;
        end else begin
            r_p_valid <= sum_valid;
            if (sum_valid) begin
                r_p_data <= w_sample;
            end
        end
    end

    // Saturation counter: counts clipped results, sticks at all-ones.
    always_ff @(posedge clk3 or posedge reset) begin
        if (reset) begin
            r_sat_count <= '0;
        end else if (sum_valid && (w_clip_hi || w_clip_lo) && (r_sat_count != '1)) begin
            r_sat_count <= r_sat_count + CNT_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: FIFO
    // ------------------------------------------------------------------
    logic [OUT_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [PTR_W:0]   r_count;
    logic [CNT_W-1:0] r_drop_count;
    logic             r_overflow;

    logic w_full;
    logic w_not_empty;
    logic w_pop;
    logic w_room;
    logic w_push;
    logic w_drop;

    assign w_full      = (r_count == C_DEPTH);
    assign w_not_empty = (r_count != '0);
    assign w_pop       = w_not_empty && out_ready;
    // A pop in the same cycle frees the slot the push needs.
    assign w_room      = !w_full || w_pop;
    assign w_push      = r_p_valid && w_room;
    assign w_drop      = r_p_valid && !w_room;

    // Sample storage; cleared on reset so the head reads zero afterwards.
    always_ff @(posedge clk3 or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= r_p_data;
        end
    end

    // Read/write pointers wrap naturally; count tracks occupancy.
    always_ff @(posedge clk3 or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (PTR_W + 1)'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - (PTR_W + 1)'(1);
            end
        end
    end

    // Drop counter and sticky overflow flag for results lost to a full FIFO.
    always_ff @(posedge clk3 or posedge reset) begin
        if (reset) begin
            r_drop_count <= '0;
            r_overflow   <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_count != '1) begin
                r_drop_count <= r_drop_count + CNT_W'(1);
            end
        end
    end

    assign out_data   = r_mem[r_rd_ptr];
    assign out_valid  = w_not_empty;
    assign fifo_full  = w_full;
    assign sat_count  = r_sat_count;
    assign drop_count = r_drop_count;
    assign overflow   = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_fir_output_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_fir_output_stage
// Description : Self-checking bench for fir_output_stage with a queue-based
//               reference model and randomized stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fir_output_stage;

    localparam int DEPTH = 4;

    logic               clk3;
    logic               reset;
    logic signed [31:0] sum_in;
    logic               sum_valid;
    logic signed [15:0] out_data;
    logic               out_valid;
    logic               out_ready;
    logic               fifo_full;
    logic [7:0]         sat_count;
    logic [7:0]         drop_count;
    logic               overflow;

    fir_output_stage #(
        .IN_W (32),
        .OUT_W(16),
        .SHIFT(15),
        .DEPTH(DEPTH),
        .CNT_W(8)
    ) dut (
        .clk3      (clk3),
        .reset     (reset),
        .sum_in    (sum_in),
        .sum_valid (sum_valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .fifo_full (fifo_full),
        .sat_count (sat_count),
        .drop_count(drop_count),
        .overflow  (overflow)
    );

    initial clk3 = 1'b0;
    always #5 clk3 = ~clk3;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model state
    int m_q[$];
    bit m_pv;
    int m_pd;
    int m_sat;
    int m_drop;
    bit m_ovf;
    int m_popped[$];
    int d_popped[$];

    // Rounded/saturated sample for a given accumulator value.
    function automatic int f_ref(input int s, output bit sat);
        longint r;
        r   = (longint'(s) + 64'sd16384) >>> 15;
        sat = 1'b0;
        if (r > 32767) begin
            sat = 1'b1;
            r   = 32767;
        end else if (r < -32768) begin
            sat = 1'b1;
            r   = -32768;
        end
        return int'(r);
    endfunction

    task automatic model_clear();
        m_q.delete();
        m_pv   = 1'b0;
        m_pd   = 0;
        m_sat  = 0;
        m_drop = 0;
        m_ovf  = 1'b0;
        m_popped.delete();
        d_popped.delete();
    endtask

    // Drive one cycle of inputs, advance the model across the edge,
    // then settle 1 time unit past the edge.
    task automatic step(input bit v, input int s, input bit rdy);
        bit pop;
        bit room;
        bit sat;
        int val;
        sum_valid = v;
        sum_in    = s;
        out_ready = rdy;
        if (out_valid && rdy) d_popped.push_back(int'(out_data));
        @(posedge clk3);
        pop  = (m_q.size() != 0) && rdy;
        room = (m_q.size() < DEPTH) || pop;
        if (pop) begin
            m_popped.push_back(m_q[0]);
            void'(m_q.pop_front());
        end
        if (m_pv) begin
            if (room) begin
                m_q.push_back(m_pd);
            end else begin
                m_ovf = 1'b1;
                if (m_drop < 255) m_drop++;
            end
        end
        m_pv = v;
        if (v) begin
            val  = f_ref(s, sat);
            m_pd = val;
            if (sat && m_sat < 255) m_sat++;
        end
        #1;
    endtask

    task automatic reset_dut();
        reset     = 1'b1;
        sum_valid = 1'b0;
        sum_in    = '0;
        out_ready = 1'b0;
        @(posedge clk3);
        #1;
        reset = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if ({out_valid, fifo_full, overflow} !== 3'b000 || out_data !== 16'sd0 ||
            sat_count !== 8'd0 || drop_count !== 8'd0) begin
            n_err++;
            $display("FAIL reset_state: got v=%b f=%b o=%b d=%0d s=%0d dr=%0d required all 0",
                     out_valid, fifo_full, overflow, out_data, sat_count, drop_count);
        end
        reset_dut();
    endtask

    task automatic test_round();
        int sv[5]  = '{32768, 16384, 16383, -16384, -16385};
        int exp[5] = '{1, 1, 0, 0, -1};
        reset_dut();
        for (int i = 0; i < 5; i++) step(1'b1, sv[i], 1'b1);
        for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b1);
        n_cmp++;
        if (d_popped.size() != 5) begin
            n_err++;
            $display("FAIL round_count: got %0d samples required 5", d_popped.size());
        end
        for (int i = 0; i < 5 && i < d_popped.size(); i++) begin
            n_cmp++;
            if (d_popped[i] !== exp[i]) begin
                n_err++;
                $display("FAIL round_val[%0d]: got %0d required %0d", i, d_popped[i], exp[i]);
            end
        end
        n_cmp++;
        if (sat_count !== 8'd0) begin
            n_err++;
            $display("FAIL round_sat: got %0d required 0", sat_count);
        end
    endtask

    task automatic test_saturation();
        int exp[3] = '{32767, -32768, 0};
        reset_dut();
        step(1'b1, 32'h7FFF_FFFF, 1'b1);
        step(1'b1, 32'h8000_0000, 1'b1);
        step(1'b1, 0, 1'b1);
        n_cmp++;
        if (sat_count !== 8'd2) begin
            n_err++;
            $display("FAIL sat_count: got %0d required 2", sat_count);
        end
        for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b1);
        n_cmp++;
        if (d_popped.size() != 3 || sat_count !== 8'd2) begin
            n_err++;
            $display("FAIL sat_after_zero: got n=%0d sat=%0d required n=3 sat=2",
                     d_popped.size(), sat_count);
        end
        for (int i = 0; i < 3 && i < d_popped.size(); i++) begin
            n_cmp++;
            if (d_popped[i] !== exp[i]) begin
                n_err++;
                $display("FAIL sat_val[%0d]: got %0d required %0d", i, d_popped[i], exp[i]);
            end
        end
    endtask

    task automatic test_stream();
        reset_dut();
        for (int k = 1; k <= 16; k++) begin
            step(1'b1, k * 1000 * 32768, 1'b1);
            if (k == 1) begin
                n_cmp++;
                if (out_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL latency_early: got out_valid=%b required 0", out_valid);
                end
            end
            if (k == 2) begin
                n_cmp++;
                if (out_valid !== 1'b1 || out_data !== 16'sd1000) begin
                    n_err++;
                    $display("FAIL latency_first: got v=%b d=%0d required v=1 d=1000",
                             out_valid, out_data);
                end
            end
        end
        for (int i = 0; i < 4; i++) step(1'b0, 0, 1'b1);
        n_cmp++;
        if (d_popped.size() != 16 || drop_count !== 8'd0) begin
            n_err++;
            $display("FAIL stream_count: got n=%0d drops=%0d required n=16 drops=0",
                     d_popped.size(), drop_count);
        end
        for (int i = 0; i < d_popped.size() && i < 16; i++) begin
            n_cmp++;
            if (d_popped[i] !== (i + 1) * 1000) begin
                n_err++;
                $display("FAIL stream_val[%0d]: got %0d required %0d", i, d_popped[i], (i + 1) * 1000);
            end
        end
    endtask

    task automatic test_overflow();
        int sv[6];
        reset_dut();
        for (int i = 0; i < 6; i++) begin
            sv[i] = int'($urandom_range(0, 60000)) - 30000;
            step(1'b1, sv[i] * 32768, 1'b0);
            n_cmp++;
            if (fifo_full !== (m_q.size() == DEPTH)) begin
                n_err++;
                $display("FAIL ovf_full_step%0d: got %b required %b", i, fifo_full, m_q.size() == DEPTH);
            end
        end
        step(1'b0, 0, 1'b0);
        n_cmp++;
        if (fifo_full !== 1'b1 || drop_count !== 8'd2 || overflow !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_state: got f=%b drops=%0d o=%b required f=1 drops=2 o=1",
                     fifo_full, drop_count, overflow);
        end
        for (int i = 0; i < 6; i++) step(1'b0, 0, 1'b1);
        n_cmp++;
        if (d_popped.size() != 4) begin
            n_err++;
            $display("FAIL ovf_drain_count: got %0d required 4", d_popped.size());
        end
        for (int i = 0; i < 4 && i < d_popped.size(); i++) begin
            n_cmp++;
            if (d_popped[i] !== sv[i]) begin
                n_err++;
                $display("FAIL ovf_drain[%0d]: got %0d required %0d", i, d_popped[i], sv[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        reset_dut();
        for (int i = 0; i < 5; i++) step(1'b1, int'($urandom), 1'b0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, int'($urandom), 1'b1);
            n_cmp++;
            if (fifo_full !== 1'b1 || drop_count !== 8'd0) begin
                n_err++;
                $display("FAIL b2b_full[%0d]: got f=%b drops=%0d required f=1 drops=0",
                         i, fifo_full, drop_count);
            end
        end
        for (int i = 0; i < 8; i++) step(1'b0, 0, 1'b1);
        n_cmp++;
        if (d_popped.size() != 13 || m_popped.size() != 13) begin
            n_err++;
            $display("FAIL b2b_count: got %0d required 13 (model %0d)", d_popped.size(), m_popped.size());
        end
        for (int i = 0; i < d_popped.size() && i < m_popped.size(); i++) begin
            n_cmp++;
            if (d_popped[i] !== m_popped[i]) begin
                n_err++;
                $display("FAIL b2b_order[%0d]: got %0d required %0d", i, d_popped[i], m_popped[i]);
            end
        end
    endtask

    task automatic test_async_reset();
        int s;
        bit sat;
        int exp;
        reset_dut();
        for (int i = 0; i < 3; i++) step(1'b1, 32'h7FFF_FFFF, 1'b0);
        step(1'b0, 0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        n_cmp++;
        if ({out_valid, fifo_full, overflow} !== 3'b000 || out_data !== 16'sd0 ||
            sat_count !== 8'd0 || drop_count !== 8'd0) begin
            n_err++;
            $display("FAIL async_reset: got v=%b d=%0d sat=%0d required v=0 d=0 sat=0",
                     out_valid, out_data, sat_count);
        end
        reset = 1'b0;
        model_clear();
        step(1'b0, 0, 1'b1);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL async_stale: got out_valid=%b required 0", out_valid);
        end
        s   = int'($urandom_range(0, 20000)) * 32768;
        exp = f_ref(s, sat);
        step(1'b1, s, 1'b1);
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL async_lat1: got out_valid=%b required 0", out_valid);
        end
        step(1'b0, 0, 1'b1);
        n_cmp++;
        if (out_valid !== 1'b1 || int'(out_data) !== exp) begin
            n_err++;
            $display("FAIL async_first: got v=%b d=%0d required v=1 d=%0d", out_valid, out_data, exp);
        end
    endtask

    task automatic test_random();
        int s;
        reset_dut();
        for (int c = 0; c < 300; c++) begin
            s = int'($urandom);
            if ($urandom_range(0, 1) == 1) s = s >>> 9;
            step(1'($urandom_range(0, 1)), s, ($urandom_range(0, 2) != 0));
            n_cmp++;
            if (out_valid !== (m_q.size() != 0) || fifo_full !== (m_q.size() == DEPTH) ||
                int'(sat_count) !== m_sat || int'(drop_count) !== m_drop || overflow !== m_ovf ||
                (m_q.size() != 0 && int'(out_data) !== m_q[0])) begin
                n_err++;
                $display("FAIL random_cycle%0d: got v=%b f=%b d=%0d sat=%0d dr=%0d o=%b required v=%b f=%b d=%0d sat=%0d dr=%0d o=%b",
                         c, out_valid, fifo_full, out_data, sat_count, drop_count, overflow,
                         m_q.size() != 0, m_q.size() == DEPTH, (m_q.size() != 0) ? m_q[0] : 0,
                         m_sat, m_drop, m_ovf);
            end
        end
    endtask

    task automatic test_counter_limit();
        reset_dut();
        for (int i = 0; i < 270; i++) step(1'b1, 32'h8000_0000, 1'b0);
        n_cmp++;
        if (sat_count !== 8'hFF || drop_count !== 8'hFF || overflow !== 1'b1) begin
            n_err++;
            $display("FAIL counter_limit: got sat=%0d drops=%0d o=%b required 255 255 1",
                     sat_count, drop_count, overflow);
        end
    endtask

    initial begin
        reset     = 1'b1;
        sum_valid = 1'b0;
        sum_in    = '0;
        out_ready = 1'b0;
        model_clear();
        test_reset();
        test_round();
        test_saturation();
        test_stream();
        test_overflow();
        test_back_to_back();
        test_async_reset();
        test_random();
        test_counter_limit();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
